// File: rtl/nios_qsys_cpu_0_oci_dct_ctrl.sv
// OCI direct-branch compressed trace sequencer: packs 2-bit branch codes and emits 36-bit trace frames.
// Optional feature macro DCT_DROP_EN: never stall the CPU, count dropped codes instead.
module nios_qsys_cpu_0_oci_dct_ctrl #(
  parameter int         CODE_W   = 2,
  parameter int         BUF_W    = 30,
  parameter int         CNT_W    = 4,
  parameter logic [1:0] TAG_FULL = 2'b10,
  parameter logic [1:0] TAG_FLSH = 2'b11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     br_valid,
  input  logic [CODE_W-1:0]        br_code,
  output logic                     br_ready,
  input  logic                     flush_req,
  output logic                     out_valid,
  output logic [2+CNT_W+BUF_W-1:0] out_data,
  input  logic                     out_ready,
  output logic [BUF_W-1:0]         dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic [7:0]               drop_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BUF_W / CODE_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state;
  logic   flush_pend;
  logic   trace_en_q;
  logic   slot_free;
  logic   full;
  logic   blocked;
  logic   take;
  logic   launch;
  logic   flush_evt;

  always_comb begin
    slot_free = ~out_valid | out_ready;
    full      = (dct_count == MAX_CNT);
    blocked   = full & ~slot_free;
`ifdef DCT_DROP_EN
    br_ready  = trace_en & (state != DRAIN);
`else
    br_ready  = trace_en & (state != DRAIN) & ~blocked;
`endif
    // A code offered while blocked is either stalled or (drop build) discarded.
    take      = br_valid & br_ready & ~blocked;
    launch    = slot_free & (full | (flush_pend & (dct_count != '0)));
    flush_evt = flush_req | (trace_en_q & ~trace_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      flush_pend <= 1'b0;
      trace_en_q <= 1'b0;
      state      <= IDLE;
    end else begin
      trace_en_q <= trace_en;

      if (launch) begin
        out_data   <= {(full ? TAG_FULL : TAG_FLSH), dct_count, dct_buffer};
        out_valid  <= 1'b1;
        // Same-cycle accept lands in the freshly cleared buffer.
        dct_buffer <= take ? BUF_W'(br_code) : '0;
        dct_count  <= take ? CNT_W'(1) : '0;
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        if (take) begin
          dct_buffer <= {dct_buffer[BUF_W-CODE_W-1:0], br_code};
          dct_count  <= dct_count + CNT_W'(1);
        end
      end

      // An empty buffer satisfies a pending flush without emitting a frame.
      flush_pend <= flush_evt | (flush_pend & ~launch & (dct_count != '0));

      case (state)
        IDLE:    if (trace_en) state <= COLLECT;
        COLLECT: if (!trace_en) state <= DRAIN;
                 else if (blocked) state <= FULL;
        FULL:    if (!trace_en) state <= DRAIN;
                 else if (slot_free) state <= COLLECT;
        DRAIN:   if ((dct_count == '0) && !out_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCT_DROP_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= '0;
    else if (br_valid && br_ready && blocked && (drop_count != 8'hFF))
      drop_count <= drop_count + 8'd1;
  end
`else
  assign drop_count = '0;
`endif

endmodule
